float_div: RTL and testbench
============================

FLOAT_DIV -- requirements
Module: float_div

Interface
REQ-001 SHALL have parameter EW, default 11, exponent width in bits (legal: 3 or more).
REQ-002 SHALL have parameter MW, default 52, stored fraction width in bits (legal: 2 or more); word width W = EW+MW+1.
REQ-003 SHALL have one clock and a synchronous, active-high reset: all state changes on the rising edge of clk, and rst is sampled on that edge.
REQ-004 clk  input  1  system clock.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 in_a  input  W  dividend, IEEE-754 layout {sign, exponent, fraction}.
REQ-007 in_b  input  W  divisor, same layout.
REQ-008 in_stb  input  1  operands valid.
REQ-009 in_ack  output  1  block ready to accept operands.
REQ-010 out_z  output  W  quotient, same layout.
REQ-011 out_stb  output  1  result valid.
REQ-012 out_ack  input  1  consumer accepts the result.

Function
REQ-013 SHALL transfer an operand pair on any edge where in_stb=1 and in_ack=1; in_ack deasserts on that edge.
REQ-014 SHALL hold one operation in flight at a time; in_ack stays 0 until the result transfer completes.
REQ-015 SHALL move through these states: GET, UNPACK, SPECIAL, NORM_IN, DIV_INIT, DIVIDE, NORM_Z, ROUND, PACK, PUT.
REQ-016 UNPACK (1 cycle): split fields; a subnormal operand gets exponent 1-bias and hidden bit 0.
REQ-017 SPECIAL (1 cycle): special operands resolve directly to PUT, so out_stb rises 2 cycles after the accept edge.
- NaN input, 0/0 or inf/inf -> canonical qNaN: sign 1, exponent all ones, fraction MSB 1, other fraction bits 0.
- x/0 (x nonzero, non-NaN) -> inf.
- inf/finite -> inf.
- 0/finite-nonzero -> zero.
- finite/inf -> zero.
- Sign of every non-NaN result is sign_a XOR sign_b.
REQ-018 NORM_IN: takes 1 cycle when both hidden bits are 1; otherwise it adds one cycle per 1-bit left shift (with exponent decrement) of each unnormalised mantissa, and the two mantissas are shifted in parallel.
REQ-019 DIV_INIT (1 cycle): exponent_z = exp_a - exp_b (EW+2-bit signed); clear remainder and quotient.
REQ-020 DIVIDE: restoring division producing one quotient bit per cycle for exactly MW+4 cycles; sticky = OR of the final remainder bits.
REQ-021 NORM_Z: takes 1 cycle and performs a 1-bit left shift plus exponent decrement if the quotient MSB is 0.
- If the result exponent is below 1-bias, it adds one cycle per 1-bit right shift, with the shifted-out bits ORed into sticky.
- Right shifts stop after MW+3 shifts, leaving a zero significand with sticky set.
REQ-022 ROUND (1 cycle): round to nearest, ties to even, using guard, round and sticky; a mantissa carry-out increments the exponent.
REQ-023 PACK (1 cycle): exponent above the maximum finite exponent -> inf with no saturation to max-finite.
- Hidden bit 0 after rounding -> exponent field 0 (subnormal or zero).
REQ-024 Latency: normal operands with a normal result SHALL raise out_stb exactly MW+11 cycles after the accept edge (63 for double precision).
REQ-025 PUT: out_stb=1 and out_z held stable until an edge with out_ack=1.
- On that edge out_stb goes to 0.
- in_ack goes to 1 on the following edge.
- out_ack already high when out_stb rises completes the transfer on the first edge of PUT.
REQ-026 in_a and in_b SHALL be ignored whenever in_ack=0.

Reset
REQ-027 On an edge with rst=1: state -> GET, in_ack=0, out_stb=0, out_z=0, all internal registers cleared.
REQ-028 in_ack SHALL rise on the first edge after rst deasserts.
REQ-029 A reset in any state, including mid-DIVIDE and PUT, SHALL abort the operation with no result delivered.

Verification
REQ-030 6.0/2.0: a=0x4018000000000000, b=0x4000000000000000 -> out_z=0x4008000000000000, out_stb rises exactly 63 cycles after accept.
REQ-031 1.0/3.0: 0x3FF0000000000000 / 0x4008000000000000 -> 0x3FD5555555555555.
REQ-032 Specials, each with out_stb 2 cycles after accept:
- 0x3FF0000000000000 / 0x0000000000000000 -> 0x7FF0000000000000.
- 0/0 -> 0xFFF8000000000000.
- 0x7FF0000000000000 / 0xC000000000000000 -> 0xFFF0000000000000.
REQ-033 Subnormal and overflow:
- 0x0000000000000003 / 0x4000000000000000 -> 0x0000000000000002 (tie to even).
- 0x0000000000000001 / 0x4000000000000000 -> 0x0000000000000000.
- 0x7FEFFFFFFFFFFFFF / 0x3FE0000000000000 -> 0x7FF0000000000000.
REQ-034 Handshake:
- Hold out_ack=0 for 20 cycles -> out_stb=1, out_z stable, in_ack=0 throughout.
- Assert rst for one cycle during DIVIDE -> out_stb=0 next edge, in_ack=1 one edge after rst release, next operation correct.
REQ-035 EW=8, MW=23: 0x40C00000 / 0x40000000 -> 0x40400000, latency 34 cycles; 0x00000003 / 0x40000000 -> 0x00000002.

Source files
------------

// File: rtl/float_div.sv
// IEEE-754 divider with one operation in flight: restoring division, round-to-nearest-even, subnormals supported.
// Normal results appear MW+11 cycles after accept and specials after 2; the result is held in PUT until out_ack.
module float_div #(
  parameter int EW = 11,
  parameter int MW = 52
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [EW+MW:0] in_a,
  input  logic [EW+MW:0] in_b,
  input  logic           in_stb,
  output logic           in_ack,
  output logic [EW+MW:0] out_z,
  output logic           out_stb,
  input  logic           out_ack
);
  localparam int W    = EW + MW + 1;
  localparam int XW   = EW + 2;
  localparam int CW   = $clog2(MW + 5);
  localparam int BIAS = (1 << (EW - 1)) - 1;
  localparam logic signed [XW-1:0] EMIN     = XW'(1 - BIAS);
  localparam logic signed [XW-1:0] EMAX     = XW'(BIAS);
  localparam logic signed [XW-1:0] E_ONE    = XW'(1);
  localparam logic [CW-1:0]        DIV_LAST = CW'(MW + 3);
  localparam logic [CW-1:0]        RSH_MAX  = CW'(MW + 3);
  localparam logic [W-1:0]         QNAN     = {1'b1, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};

  typedef enum logic [3:0] {
    GET, UNPACK, SPECIAL, NORM_IN, DIV_INIT, DIVIDE, NORM_Z, ROUND, PACK, PUT
  } state_t;

  state_t state_q, state_d;

  logic [W-1:0]           a_raw, b_raw;
  logic [MW:0]            a_m, b_m;
  logic signed [XW-1:0]   a_e, b_e, z_e;
  logic                   z_s;
  logic [MW+1:0]          rem;
  logic [MW+3:0]          q;
  logic [CW-1:0]          cnt;
  logic                   rsh;
  logic [MW+2:0]          z_m;
  logic                   sticky;
  logic [MW:0]            z_r;

  // Field decode of the latched operands
  logic [EW-1:0] a_exp, b_exp;
  logic [MW-1:0] a_frac, b_frac;
  logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

  assign a_exp  = a_raw[W-2:MW];
  assign b_exp  = b_raw[W-2:MW];
  assign a_frac = a_raw[MW-1:0];
  assign b_frac = b_raw[MW-1:0];
  assign a_nan  = (&a_exp) && (|a_frac);
  assign b_nan  = (&b_exp) && (|b_frac);
  assign a_inf  = (&a_exp) && !(|a_frac);
  assign b_inf  = (&b_exp) && !(|b_frac);
  assign a_zero = !(|a_exp) && !(|a_frac);
  assign b_zero = !(|b_exp) && !(|b_frac);

  logic          spec_hit;
  logic [W-1:0]  spec_z;

  always_comb begin
    spec_hit = 1'b1;
    spec_z   = '0;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf))
      spec_z = QNAN;
    else if (a_inf || b_zero)
      spec_z = {z_s, {EW{1'b1}}, {MW{1'b0}}};
    else if (a_zero || b_inf)
      spec_z = {z_s, {(W-1){1'b0}}};
    else
      spec_hit = 1'b0;
  end

  logic          rem_ge;
  logic [MW+1:0] rem_sub;
  logic [CW-1:0] cnt_inc;

  assign rem_ge  = rem >= {1'b0, b_m};
  assign rem_sub = rem_ge ? rem - {1'b0, b_m} : rem;
  assign cnt_inc = cnt + CW'(1);

  // NORM_Z: first cycle fixes the quotient MSB, later cycles denormalise
  logic signed [XW-1:0] e_dec, e_inc, e_first;
  logic                 nz_stay;

  assign e_dec   = z_e - E_ONE;
  assign e_inc   = z_e + E_ONE;
  assign e_first = q[MW+3] ? z_e : e_dec;
  assign nz_stay = rsh ? ((e_inc < EMIN) && (cnt_inc < RSH_MAX)) : (e_first < EMIN);

  logic [MW:0]   r_mant;
  logic          r_up;
  logic [MW+1:0] r_sum;

  assign r_mant = z_m[MW+2:2];
  assign r_up   = z_m[1] & (z_m[0] | sticky | r_mant[0]);
  assign r_sum  = {1'b0, r_mant} + {{(MW+1){1'b0}}, r_up};

  logic [W-1:0] pack_z;

  always_comb begin
    pack_z = {z_s, {EW{1'b0}}, z_r[MW-1:0]};
    if (z_e > EMAX)
      pack_z = {z_s, {EW{1'b1}}, {MW{1'b0}}};
    else if (z_r[MW])
      pack_z = {z_s, z_e[EW-1:0] + EMAX[EW-1:0], z_r[MW-1:0]};
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= GET;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      GET:      if (in_ack && in_stb) state_d = UNPACK;
      UNPACK:   state_d = SPECIAL;
      SPECIAL:  state_d = spec_hit ? PUT : NORM_IN;
      NORM_IN:  if (a_m[MW] && b_m[MW]) state_d = DIV_INIT;
      DIV_INIT: state_d = DIVIDE;
      DIVIDE:   if (cnt == DIV_LAST) state_d = NORM_Z;
      NORM_Z:   if (!nz_stay) state_d = ROUND;
      ROUND:    state_d = PACK;
      PACK:     state_d = PUT;
      PUT:      if (out_ack) state_d = GET;
      default:  state_d = GET;
    endcase
  end

  assign out_stb = (state_q == PUT);

  always_ff @(posedge clk) begin
    if (rst) begin
      in_ack <= 1'b0;
      out_z  <= '0;
      a_raw  <= '0;
      b_raw  <= '0;
      a_m    <= '0;
      b_m    <= '0;
      a_e    <= '0;
      b_e    <= '0;
      z_e    <= '0;
      z_s    <= 1'b0;
      rem    <= '0;
      q      <= '0;
      cnt    <= '0;
      rsh    <= 1'b0;
      z_m    <= '0;
      sticky <= 1'b0;
      z_r    <= '0;
    end else begin
      case (state_q)
        GET: begin
          in_ack <= ~(in_ack & in_stb);
          if (in_ack && in_stb) begin
            a_raw <= in_a;
            b_raw <= in_b;
          end
        end
        UNPACK: begin
          a_m <= {|a_exp, a_frac};
          b_m <= {|b_exp, b_frac};
          a_e <= (|a_exp) ? $signed({2'b00, a_exp}) - EMAX : EMIN;
          b_e <= (|b_exp) ? $signed({2'b00, b_exp}) - EMAX : EMIN;
          z_s <= a_raw[W-1] ^ b_raw[W-1];
        end
        SPECIAL: if (spec_hit) out_z <= spec_z;
        NORM_IN: begin
          if (!a_m[MW]) begin
            a_m <= a_m << 1;
            a_e <= a_e - E_ONE;
          end
          if (!b_m[MW]) begin
            b_m <= b_m << 1;
            b_e <= b_e - E_ONE;
          end
        end
        DIV_INIT: begin
          z_e    <= a_e - b_e;
          rem    <= {1'b0, a_m};
          q      <= '0;
          cnt    <= '0;
          rsh    <= 1'b0;
          sticky <= 1'b0;
        end
        DIVIDE: begin
          q   <= {q[MW+2:0], rem_ge};
          rem <= rem_sub << 1;
          cnt <= cnt_inc;
        end
        NORM_Z: begin
          if (!rsh) begin
            if (q[MW+3]) begin
              z_m    <= q[MW+3:1];
              sticky <= q[0] | (|rem);
            end else begin
              z_m    <= q[MW+2:0];
              sticky <= |rem;
              z_e    <= e_dec;
            end
            rsh <= nz_stay;
            cnt <= '0;
          end else begin
            z_m    <= z_m >> 1;
            sticky <= sticky | z_m[0];
            z_e    <= e_inc;
            cnt    <= cnt_inc;
          end
        end
        ROUND: begin
          if (r_sum[MW+1]) begin
            z_r <= {1'b1, {MW{1'b0}}};
            z_e <= e_inc;
          end else begin
            z_r <= r_sum[MW:0];
          end
        end
        PACK: out_z <= pack_z;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_float_div.sv
// Scoreboarded bench for float_div at double and single precision.
module tb_float_div;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [63:0] d_a, d_b, d_z;
  logic        d_in_stb, d_in_ack, d_out_stb, d_out_ack;
  logic [31:0] s_a, s_b, s_z;
  logic        s_in_stb, s_in_ack, s_out_stb, s_out_ack;

  float_div #(.EW(11), .MW(52)) u_dp (
    .clk(clk), .rst(rst), .in_a(d_a), .in_b(d_b), .in_stb(d_in_stb), .in_ack(d_in_ack),
    .out_z(d_z), .out_stb(d_out_stb), .out_ack(d_out_ack)
  );

  float_div #(.EW(8), .MW(23)) u_sp (
    .clk(clk), .rst(rst), .in_a(s_a), .in_b(s_b), .in_stb(s_in_stb), .in_ack(s_in_ack),
    .out_z(s_z), .out_stb(s_out_stb), .out_ack(s_out_ack)
  );

  typedef struct {
    logic [63:0] z;
    int          lat;
    int          acc;
    string       name;
  } exp_t;

  exp_t dq[$];
  exp_t sq[$];
  int   n_chk = 0;
  int   n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, need %h", name, act, req);
  endtask

  // Monitors: latency checked on the rising out_stb, value on the transfer cycle
  logic d_prev = 1'b0;
  logic s_prev = 1'b0;

  always @(negedge clk) begin
    if (d_out_stb && !d_prev) begin
      if (dq.size() == 0) begin
        n_chk++;
        $display("FAIL dp unexpected result: got %h, need no output", d_z);
      end else if (dq[0].lat > 0) begin
        check({dq[0].name, " latency"}, 64'(cyc - dq[0].acc), 64'(dq[0].lat));
      end
    end
    if (d_out_stb && d_out_ack && dq.size() > 0) begin
      check(dq[0].name, d_z, dq[0].z);
      void'(dq.pop_front());
    end
    d_prev = d_out_stb;
  end

  always @(negedge clk) begin
    if (s_out_stb && !s_prev) begin
      if (sq.size() == 0) begin
        n_chk++;
        $display("FAIL sp unexpected result: got %h, need no output", s_z);
      end else if (sq[0].lat > 0) begin
        check({sq[0].name, " latency"}, 64'(cyc - sq[0].acc), 64'(sq[0].lat));
      end
    end
    if (s_out_stb && s_out_ack && sq.size() > 0) begin
      check(sq[0].name, {32'h0, s_z}, sq[0].z);
      void'(sq.pop_front());
    end
    s_prev = s_out_stb;
  end

  task automatic issue(input bit sp, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] z, input int lat, input string name, input bit track);
    int   t;
    exp_t e;
    t = 0;
    while (!(sp ? s_in_ack : d_in_ack) && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!(sp ? s_in_ack : d_in_ack)) begin
      n_chk++;
      $display("FAIL %s in_ack wait: got 0, need 1", name);
      return;
    end
    if (sp) begin
      s_a = a[31:0]; s_b = b[31:0]; s_in_stb = 1'b1;
    end else begin
      d_a = a; d_b = b; d_in_stb = 1'b1;
    end
    @(negedge clk);
    d_in_stb = 1'b0; s_in_stb = 1'b0;
    d_a = ~d_a; d_b = ~d_b; s_a = ~s_a; s_b = ~s_b;
    e.z = z; e.lat = lat; e.acc = cyc; e.name = name;
    if (track) begin
      if (sp) sq.push_back(e);
      else    dq.push_back(e);
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((dq.size() != 0 || sq.size() != 0) && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (dq.size() != 0 || sq.size() != 0) begin
      n_chk++;
      $display("FAIL drain: got %0d results outstanding, need 0", dq.size() + sq.size());
      dq.delete();
      sq.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t;
    int bad;
    d_a = '0; d_b = '0; d_in_stb = 1'b0; d_out_ack = 1'b1;
    s_a = '0; s_b = '0; s_in_stb = 1'b0; s_out_ack = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset dp in_ack", d_in_ack, 0);
    check("reset dp out_stb", d_out_stb, 0);
    check("reset dp out_z", d_z, 0);
    check("reset sp in_ack", s_in_ack, 0);
    rst = 1'b0;
    @(negedge clk);
    check("dp in_ack after reset", d_in_ack, 1);
    check("sp in_ack after reset", s_in_ack, 1);

    issue(0, 64'h4018000000000000, 64'h4000000000000000, 64'h4008000000000000, 63, "dp 6/2", 1);
    issue(0, 64'h3FF0000000000000, 64'h4008000000000000, 64'h3FD5555555555555, 63, "dp 1/3", 1);
    issue(0, 64'h3FF0000000000000, 64'h0000000000000000, 64'h7FF0000000000000, 2, "dp 1/0", 1);
    issue(0, 64'h0000000000000000, 64'h0000000000000000, 64'hFFF8000000000000, 2, "dp 0/0", 1);
    issue(0, 64'h7FF0000000000000, 64'hC000000000000000, 64'hFFF0000000000000, 2, "dp inf/-2", 1);
    issue(0, 64'h0000000000000003, 64'h4000000000000000, 64'h0000000000000002, 0, "dp sub tie", 1);
    issue(0, 64'h0000000000000001, 64'h4000000000000000, 64'h0000000000000000, 0, "dp sub zero", 1);
    issue(0, 64'h7FEFFFFFFFFFFFFF, 64'h3FE0000000000000, 64'h7FF0000000000000, 0, "dp overflow", 1);
    drain();

    issue(1, 64'h40C00000, 64'h40000000, 64'h40400000, 34, "sp 6/2", 1);
    issue(1, 64'h00000003, 64'h40000000, 64'h00000002, 0, "sp sub tie", 1);
    drain();

    d_out_ack = 1'b0;
    issue(0, 64'h4018000000000000, 64'h4000000000000000, 64'h4008000000000000, 63, "dp stall 6/2", 1);
    t = 0;
    while (!d_out_stb && t < 100) begin
      @(negedge clk);
      t++;
    end
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (!d_out_stb || d_z !== 64'h4008000000000000 || d_in_ack) bad++;
    end
    check("stall hold bad cycles", 64'(bad), 0);
    d_out_ack = 1'b1;
    drain();

    issue(0, 64'h3FF0000000000000, 64'h4008000000000000, 64'h0, 0, "dp aborted", 0);
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort out_stb", d_out_stb, 0);
    check("abort in_ack", d_in_ack, 0);
    check("abort out_z cleared", d_z, 0);
    rst = 1'b0;
    @(negedge clk);
    check("in_ack after abort", d_in_ack, 1);
    issue(0, 64'h3FF0000000000000, 64'h4008000000000000, 64'h3FD5555555555555, 63, "dp 1/3 after abort", 1);
    drain();
    repeat (5) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
